// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall generator for the EX-stage operand muxes.
// Keeps its own shadow copy of the EX and MEM destination fields, so no datapath state is needed.
module fwd_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    localparam logic [RA_W-1:0]  REG_ZERO = {RA_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            ex_v_r;
    logic            ex_wr_r;
    logic            ex_ld_r;
    logic [RA_W-1:0] ex_dst_r;
    logic            mem_v_r;
    logic            mem_wr_r;
    logic [RA_W-1:0] mem_dst_r;

    logic [1:0]       fwd_a_r;
    logic [1:0]       fwd_b_r;
    logic [CNT_W-1:0] stall_count_r;

    logic       hit_ex_rs_s;
    logic       hit_ex_rt_s;
    logic       hit_mem_rs_s;
    logic       hit_mem_rt_s;
    logic       stall_s;
    logic       advance_s;
    logic       kill_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // A younger writer of a nonzero register that the consumer actually reads.
    function automatic logic src_hit(
        input logic            v,
        input logic            wr,
        input logic [RA_W-1:0] dst,
        input logic [RA_W-1:0] src,
        input logic            use_src
    );
        return v & wr & (dst == src) & (src != REG_ZERO) & use_src;
    endfunction

    // EX producer beats MEM producer: the youngest value is the architecturally correct one.
    function automatic logic [1:0] pick_sel(
        input logic kill,
        input logic hit_ex,
        input logic hit_mem
    );
        logic [1:0] sel;
        if (kill) begin
            sel = SEL_RF;
        end else if (hit_ex) begin
            sel = SEL_EXM;
        end else if (hit_mem) begin
            sel = SEL_MWB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    assign hit_ex_rs_s  = src_hit(ex_v_r,  ex_wr_r,  ex_dst_r,  id_rs, id_use_rs);
    assign hit_ex_rt_s  = src_hit(ex_v_r,  ex_wr_r,  ex_dst_r,  id_rt, id_use_rt);
    assign hit_mem_rs_s = src_hit(mem_v_r, mem_wr_r, mem_dst_r, id_rs, id_use_rs);
    assign hit_mem_rt_s = src_hit(mem_v_r, mem_wr_r, mem_dst_r, id_rt, id_use_rt);

    // Load result is not available until MEM, so a consumer directly behind it must wait one cycle.
    assign stall_s   = id_valid & ~flush & (hit_ex_rs_s | hit_ex_rt_s) & ex_ld_r;
    assign advance_s = id_valid & ~stall_s & ~flush;
    assign kill_s    = stall_s | flush | ~id_valid;

    // Next-cycle operand selects for the instruction about to enter EX.
    always_comb begin
        fwd_a_s = SEL_RF;
        fwd_b_s = SEL_RF;
        fwd_a_s = pick_sel(kill_s, hit_ex_rs_s, hit_mem_rs_s);
        fwd_b_s = pick_sel(kill_s, hit_ex_rt_s, hit_mem_rt_s);
    end

    // Shadow EX/MEM pipeline; a stalled or squashed slot becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_r    <= 1'b0;
            ex_wr_r   <= 1'b0;
            ex_ld_r   <= 1'b0;
            ex_dst_r  <= REG_ZERO;
            mem_v_r   <= 1'b0;
            mem_wr_r  <= 1'b0;
            mem_dst_r <= REG_ZERO;
        end else begin
            if (advance_s) begin
                ex_v_r   <= 1'b1;
                ex_wr_r  <= id_reg_write;
                ex_ld_r  <= id_mem_to_reg;
                ex_dst_r <= id_dst;
            end else begin
                ex_v_r   <= 1'b0;
                ex_wr_r  <= 1'b0;
                ex_ld_r  <= 1'b0;
                ex_dst_r <= REG_ZERO;
            end
            mem_v_r   <= ex_v_r;
            mem_wr_r  <= ex_wr_r;
            mem_dst_r <= ex_dst_r;
        end
    end

    // Operand selects registered so they line up with the instruction's EX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_r <= SEL_RF;
            fwd_b_r <= SEL_RF;
        end else begin
            fwd_a_r <= fwd_a_s;
            fwd_b_r <= fwd_b_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall       = stall_s;
    assign ex_fwd_a    = fwd_a_r;
    assign ex_fwd_b    = fwd_b_r;
    assign stall_count = stall_count_r;

endmodule
